// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline and multi-cycle EX handshake.
// Optional stall-cycle perf counter enabled by defining STALL_CTRL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    input  logic        stallreq_id,
    input  logic        ex_mc_req,
    input  logic        mc_done,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        mc_start,
    output logic        mc_cancel,
    output logic        mc_result_valid,
    output logic        mc_timeout_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        MC_WAIT,
        MC_DONE,
        FLUSH
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // stall/flush act in the same cycle as the request that causes them
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_req)
                    flush = 1'b1;
                else if (ex_mc_req)
                    stall = STALL_EX;
                else if (stallreq_id)
                    stall = STALL_ID;
            end
            MC_WAIT: begin
                if (flush_req)
                    flush = 1'b1;
                else
                    stall = STALL_EX;
            end
            MC_DONE: begin
                flush = flush_req;
            end
            FLUSH: begin
                stall = STALL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            mc_start        <= 1'b0;
            mc_cancel       <= 1'b0;
            mc_result_valid <= 1'b0;
            mc_timeout_err  <= 1'b0;
        end else begin
            mc_start        <= 1'b0;
            mc_cancel       <= 1'b0;
            mc_result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                    end else if (ex_mc_req) begin
                        state    <= MC_WAIT;
                        mc_start <= 1'b1;
                        cnt      <= '0;
                    end
                end
                MC_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush_req) begin
                        state     <= FLUSH;
                        mc_cancel <= 1'b1;
                    end else if (mc_done) begin
                        state           <= MC_DONE;
                        mc_result_valid <= 1'b1;
                    end else if (cnt_last) begin
                        // give up: instruction leaves EX with an undefined result
                        state          <= IDLE;
                        mc_cancel      <= 1'b1;
                        mc_timeout_err <= 1'b1;
                    end
                end
                MC_DONE: begin
                    state <= flush_req ? FLUSH : IDLE;
                end
                FLUSH: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall != STALL_NONE && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl.
// Instance a uses default timeout, instance b uses MC_TIMEOUT=8.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] EX = 6'b001111;
    localparam logic [5:0] ID = 6'b000111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_req = 1'b0;
    logic stallreq_id = 1'b0;
    logic ex_mc_req = 1'b0;
    logic mc_done = 1'b0;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush;
    logic        a_start, b_start;
    logic        a_cancel, b_cancel;
    logic        a_rv, b_rv;
    logic        a_err, b_err;
    logic [31:0] a_cyc, b_cyc;

    int sel = 0;
    int perf_cnt = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        start;
        logic        cancel;
        logic        rv;
        logic        err;
        logic [31:0] cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl dut_a (
        .clk(clk), .rst(rst),
        .flush_req(flush_req), .stallreq_id(stallreq_id),
        .ex_mc_req(ex_mc_req), .mc_done(mc_done),
        .stall(a_stall), .flush(a_flush),
        .mc_start(a_start), .mc_cancel(a_cancel),
        .mc_result_valid(a_rv), .mc_timeout_err(a_err),
        .stall_cycles(a_cyc)
    );

    pipe_stall_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .flush_req(flush_req), .stallreq_id(stallreq_id),
        .ex_mc_req(ex_mc_req), .mc_done(mc_done),
        .stall(b_stall), .flush(b_flush),
        .mc_start(b_start), .mc_cancel(b_cancel),
        .mc_result_valid(b_rv), .mc_timeout_err(b_err),
        .stall_cycles(b_cyc)
    );

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t x;
        x = sb.pop_front();
        if (sel == 0) begin
            chk(x.tag, "stall", 32'(a_stall), 32'(x.stall));
            chk(x.tag, "flush", 32'(a_flush), 32'(x.flush));
            chk(x.tag, "start", 32'(a_start), 32'(x.start));
            chk(x.tag, "cancel", 32'(a_cancel), 32'(x.cancel));
            chk(x.tag, "rvalid", 32'(a_rv), 32'(x.rv));
            chk(x.tag, "err", 32'(a_err), 32'(x.err));
            chk(x.tag, "cycles", a_cyc, x.cyc);
        end else begin
            chk(x.tag, "stall", 32'(b_stall), 32'(x.stall));
            chk(x.tag, "flush", 32'(b_flush), 32'(x.flush));
            chk(x.tag, "start", 32'(b_start), 32'(x.start));
            chk(x.tag, "cancel", 32'(b_cancel), 32'(x.cancel));
            chk(x.tag, "rvalid", 32'(b_rv), 32'(x.rv));
            chk(x.tag, "err", 32'(b_err), 32'(x.err));
            chk(x.tag, "cycles", b_cyc, x.cyc);
        end
    endtask

    task automatic step(input logic f, input logic s,
                        input logic e, input logic d,
                        input logic [5:0] st, input logic fl,
                        input logic sa, input logic ca,
                        input logic rv, input logic er,
                        input string tag);
        exp_t x;
        @(negedge clk);
        flush_req   = f;
        stallreq_id = s;
        ex_mc_req   = e;
        mc_done     = d;
        x.stall  = st;
        x.flush  = fl;
        x.start  = sa;
        x.cancel = ca;
        x.rv     = rv;
        x.err    = er;
`ifdef STALL_CTRL_PERF_EN
        x.cyc    = 32'(perf_cnt);
`else
        x.cyc    = 32'h0;
`endif
        x.tag    = tag;
        sb.push_back(x);
        if (st != 6'd0) perf_cnt++;
        #2;
        compare_head();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush_req = 1'b0;
        stallreq_id = 1'b0;
        ex_mc_req = 1'b0;
        mc_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        perf_cnt = 0;
    endtask

    initial begin
        // reset and idle
        sel = 0;
        do_reset();
        step(0,0,0,0, 6'd0,0,0,0,0,0, "reset_idle0");
        step(0,0,0,0, 6'd0,0,0,0,0,0, "reset_idle1");

        // load-use stall for three cycles
        for (int i = 0; i < 3; i++)
            step(0,1,0,0, ID,0,0,0,0,0, "load_use");
        step(0,0,0,0, 6'd0,0,0,0,0,0, "load_use_end");
        step(0,0,0,0, 6'd0,0,0,0,0,0, "load_use_nostart");

        // multi-cycle op completing 10 cycles after mc_start
        step(0,0,1,0, EX,0,0,0,0,0, "mc_req");
        step(0,0,1,0, EX,0,1,0,0,0, "mc_start");
        for (int i = 2; i <= 10; i++)
            step(0, (i >= 5 && i <= 7), 1, 0, EX,0,0,0,0,0, "mc_wait");
        step(0,0,1,1, EX,0,0,0,0,0, "mc_done_in");
        step(0,0,1,0, 6'd0,0,0,0,1,0, "mc_done_state");
        step(0,0,0,1, 6'd0,0,0,0,0,0, "no_restart");
        step(0,0,0,0, 6'd0,0,0,0,0,0, "stray_done_ignored");

        // done on the timeout cycle: done wins
        sel = 1;
        do_reset();
        step(0,0,1,0, EX,0,0,0,0,0, "lim_req");
        step(0,0,1,0, EX,0,1,0,0,0, "lim_start");
        for (int i = 2; i <= 7; i++)
            step(0,0,1,0, EX,0,0,0,0,0, "lim_wait");
        step(0,0,1,1, EX,0,0,0,0,0, "lim_done_in");
        step(0,0,1,0, 6'd0,0,0,0,1,0, "lim_done_wins");
        step(0,0,0,0, 6'd0,0,0,0,0,0, "lim_no_cancel");

        // timeout after 8 MC_WAIT cycles
        step(0,0,1,0, EX,0,0,0,0,0, "to_req");
        step(0,0,1,0, EX,0,1,0,0,0, "to_start");
        for (int i = 2; i <= 8; i++)
            step(0,0,1,0, EX,0,0,0,0,0, "to_wait");
        step(0,0,0,0, 6'd0,0,0,1,0,1, "to_cancel");
        step(0,0,0,0, 6'd0,0,0,0,0,1, "to_err_sticky0");
        step(0,0,0,0, 6'd0,0,0,0,0,1, "to_err_sticky1");

        // flush in 4th MC_WAIT cycle with a load-use request
        step(0,0,1,0, EX,0,0,0,0,1, "fl_req");
        step(0,0,1,0, EX,0,1,0,0,1, "fl_start");
        step(0,0,1,0, EX,0,0,0,0,1, "fl_wait1");
        step(0,0,1,0, EX,0,0,0,0,1, "fl_wait2");
        step(1,1,1,0, 6'd0,1,0,0,0,1, "fl_flush");
        step(0,0,0,0, 6'd0,0,0,1,0,1, "fl_cancel");
        step(0,0,0,0, 6'd0,0,0,0,0,1, "fl_idle");

        // held flush_req: flush, gap, one extra flush from IDLE
        step(1,0,0,0, 6'd0,1,0,0,0,1, "held_flush1");
        step(1,0,0,0, 6'd0,0,0,0,0,1, "held_gap");
        step(1,0,0,0, 6'd0,1,0,0,0,1, "held_flush2");
        step(0,0,0,0, 6'd0,0,0,0,0,1, "held_end");
        step(0,0,0,0, 6'd0,0,0,0,0,1, "held_idle");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
